// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard controller: shift-register scoreboard of in-flight instructions,
// per-operand forwarding selects, load-use stall, branch flush, RF writeback and counters.
module pipe_hazard_unit #(
  parameter int REG_W    = 2,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16,
  parameter int FSEL_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rs1,
  input  logic              issue_rs1_used,
  input  logic [REG_W-1:0]  issue_rs2,
  input  logic              issue_rs2_used,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              issue_wr,
  input  logic              issue_load,
  input  logic              branch_taken,
  output logic              issue_ready,
  output logic              stall,
  output logic              flush,
  output logic [FSEL_W-1:0] fwd_sel1,
  output logic [FSEL_W-1:0] fwd_sel2,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic FWD_ON = (FWD_EN != 0);

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] wr_r;
  logic [STAGES-1:0] load_r;
  logic [REG_W-1:0]  rd_r [STAGES];

  logic              hazard1_s;
  logic              hazard2_s;
  logic [FSEL_W-1:0] sel1_s;
  logic [FSEL_W-1:0] sel2_s;
  logic              stall_s;
  logic              flush_s;
  logic              ready_s;

  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [CNT_W-1:0]  retire_cnt_r;

  // Youngest matching producer wins: scan oldest to youngest so the lowest index is kept last.
  function automatic logic [FSEL_W:0] resolve_src(
    input logic              used,
    input logic [REG_W-1:0]  src,
    input logic [STAGES-1:0] vld,
    input logic [STAGES-1:0] wr,
    input logic [STAGES-1:0] ld,
    input logic [REG_W-1:0]  rd [STAGES]
  );
    logic              hit;
    logic              m;
    logic              ld_hit;
    logic              haz;
    logic [FSEL_W-1:0] idx;
    logic [FSEL_W-1:0] avail;
    logic [FSEL_W-1:0] sel;
    hit    = 1'b0;
    ld_hit = 1'b0;
    idx    = {FSEL_W{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      m      = vld[k] & wr[k] & (rd[k] == src);
      hit    = hit | m;
      idx    = m ? FSEL_W'(k) : idx;
      ld_hit = m ? ld[k] : ld_hit;
    end
    avail = ld_hit ? FSEL_W'(LOAD_LAT) : FSEL_W'(1);
    haz   = used & hit & (~FWD_ON | (idx < avail));
    sel   = (used & hit & ~haz) ? (idx + FSEL_W'(1)) : {FSEL_W{1'b0}};
    return {haz, sel};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    return (en && (cnt != {CNT_W{1'b1}})) ? (cnt + CNT_W'(1)) : cnt;
  endfunction

  // Hazard resolution and issue decision; everything is forced quiet while reset is held.
  always_comb begin
    {hazard1_s, sel1_s} = resolve_src(issue_rs1_used, issue_rs1, valid_r, wr_r, load_r, rd_r);
    {hazard2_s, sel2_s} = resolve_src(issue_rs2_used, issue_rs2, valid_r, wr_r, load_r, rd_r);
    flush_s = reset & branch_taken;
    stall_s = reset & issue_valid & (hazard1_s | hazard2_s) & ~branch_taken;
    ready_s = reset & issue_valid & ~stall_s & ~flush_s;
  end

  // Scoreboard shift: accepted instruction enters entry 0, otherwise a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= {STAGES{1'b0}};
      wr_r    <= {STAGES{1'b0}};
      load_r  <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        rd_r[k] <= {REG_W{1'b0}};
      end
    end else begin
      valid_r <= {valid_r[STAGES-2:0], ready_s};
      wr_r    <= {wr_r[STAGES-2:0], ready_s & issue_wr};
      load_r  <= {load_r[STAGES-2:0], ready_s & issue_load};
      rd_r[0] <= ready_s ? issue_rd : {REG_W{1'b0}};
      for (int k = 1; k < STAGES; k++) begin
        rd_r[k] <= rd_r[k-1];
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
      retire_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r  <= sat_inc(stall_cnt_r, stall_s);
      flush_cnt_r  <= sat_inc(flush_cnt_r, flush_s);
      retire_cnt_r <= sat_inc(retire_cnt_r, valid_r[STAGES-1]);
    end
  end

  assign issue_ready = ready_s;
  assign stall       = stall_s;
  assign flush       = flush_s;
  assign fwd_sel1    = reset ? sel1_s : {FSEL_W{1'b0}};
  assign fwd_sel2    = reset ? sel2_s : {FSEL_W{1'b0}};
  assign rf_we       = valid_r[STAGES-1] & wr_r[STAGES-1];
  assign rf_waddr    = valid_r[STAGES-1] ? rd_r[STAGES-1] : {REG_W{1'b0}};
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;
  assign retire_cnt  = retire_cnt_r;

endmodule
